fp_alu_dispatch: RTL and testbench
==================================

Name: fp_alu_dispatch

Overview:
Upstream issue stage for the IEEE-754 single-precision ALU top level. It accepts float operation requests on a valid/ready interface and buffers them in a small FIFO. It flushes subnormal inputs to signed zero, then drives the ALU's one-cycle trig protocol and waits for the ALU's vld. Each ALU result, or a timeout marker, is returned on a valid/ready result interface with the opcode that produced it.

Parameters:
DEPTH, 4, request FIFO entries; power of two, at least 2
TIMEOUT, 1000, cycles to wait for alu_vld after trig before declaring a timeout

Ports:
sys_clk  in  1  clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
in_vld  in  1  request valid
in_rdy  out  1  request ready
in_a  in  32  operand A, IEEE-754 single
in_b  in  32  operand B, IEEE-754 single
in_op  in  2  00 add, 01 sub, 10 mul, 11 div
alu_data1  out  32  to ALU data1_in
alu_data2  out  32  to ALU data2_in
alu_opcode  out  2  to ALU opcode
alu_trig  out  1  to ALU trig, one-cycle pulse
alu_data_out  in  32  ALU result
alu_vld  in  1  ALU result valid
alu_work  in  1  ALU busy
res_vld  out  1  result valid
res_rdy  in  1  result ready
res_data  out  32  result
res_op  out  2  opcode of this result
res_timeout  out  1  result is a timeout marker
fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, active-low):
  - Every output resets to 0, except in_rdy, which is 1 once the FIFO is empty.
  - FIFO pointers and count clear, the FSM goes to IDLE and the timeout counter clears.
  - Reset during ISSUE or WAIT abandons the in-flight operation. No result is produced for it.
- FIFO write:
  - Push occurs on in_vld && in_rdy.
  - in_rdy = (fifo_cnt < DEPTH). It depends on count only, so there is no same-cycle pop-through when full.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- Subnormal flush, applied at write to each operand independently:
  - If exp[30:23]==0 and mant[22:0]!=0, clear mant and keep the sign.
  - Zeros, normals, infinities and NaNs pass through unchanged.
- The FSM has three states: IDLE, ISSUE and WAIT.
  - IDLE: if fifo_cnt>0 && !alu_work && !res_vld, pop the head into the operand registers and go to ISSUE. alu_vld is ignored in IDLE.
  - ISSUE (exactly 1 cycle):
    - alu_trig=1, alu_data1/alu_data2/alu_opcode = popped entry.
    - Clear the timeout counter and go to WAIT.
  - WAIT:
    - alu_trig=0 and alu_data1/alu_data2 = 0; alu_opcode holds the issued value.
    - The counter increments each cycle.
    - On alu_vld: at that edge set res_data=alu_data_out, res_op=issued op, res_timeout=0, res_vld=1, then go to IDLE.
    - Else, if counter==TIMEOUT-1: set res_data=32'hFFFF_FFFF, res_timeout=1, res_vld=1, then go to IDLE.
    - alu_vld wins over timeout in the same cycle.
- Outside ISSUE, alu_data1 and alu_data2 are always 0 and alu_trig is 0.
- Result register:
  - res_vld stays high, with res_data, res_op and res_timeout stable, until res_vld && res_rdy. It clears on that edge.
  - A new issue requires res_vld==0 in IDLE, so at most one operation is in flight.
- Latency:
  - A request pushed into an empty FIFO at edge t, with the ALU idle and the result slot empty, gives alu_trig high in the cycle after edge t+1.
  - With an ALU vld at cycle k after trig, res_vld rises at the edge that samples alu_vld.
- A spurious alu_vld in IDLE or ISSUE has no effect.

Test Plan:
1. Push a=3F800000, b=40000000, op=00; bench ALU answers 40400000 three cycles after trig → exactly one trig cycle carrying those values; res_vld with res_data=40400000, res_op=00, res_timeout=0.
2. Push a=80000001, b=00400000, op=10 → alu_data1=80000000 and alu_data2=00000000 in the trig cycle.
3. Hold alu_work=1 and push 5 requests back-to-back → fifo_cnt reaches 4, in_rdy=0, the fifth is held; no trig occurs. Release alu_work → trig follows, fifo_cnt=3, in_rdy=1, the fifth is accepted.
4. Hold res_rdy=0 with 2 requests queued → after the first result, no second trig while res_vld=1. Pulse res_rdy → res_vld drops and the next trig follows one cycle later.
5. Never assert alu_vld → res_vld rises 1000 cycles after trig with res_data=FFFFFFFF, res_timeout=1; the next queued request then issues.
6. Assert sys_rst_n=0 mid-WAIT, release, then pulse alu_vld → no result, fifo_cnt=0, all outputs 0, in_rdy=1.

Source files
------------

// File: rtl/fp_alu_dispatch_if.sv
// Request, ALU-side and result signals of the float dispatch stage.
// slave is the dispatcher's own view; master is the view of everything around it.
interface fp_alu_dispatch_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic            in_vld;
   logic            in_rdy;
   logic [31:0]     in_a;
   logic [31:0]     in_b;
   logic [1:0]      in_op;
   logic [31:0]     alu_data1;
   logic [31:0]     alu_data2;
   logic [1:0]      alu_opcode;
   logic            alu_trig;
   logic [31:0]     alu_data_out;
   logic            alu_vld;
   logic            alu_work;
   logic            res_vld;
   logic            res_rdy;
   logic [31:0]     res_data;
   logic [1:0]      res_op;
   logic            res_timeout;
   logic [CntW-1:0] fifo_cnt;

   modport slave (
      input  in_vld, in_a, in_b, in_op, alu_data_out, alu_vld, alu_work, res_rdy,
      output in_rdy, alu_data1, alu_data2, alu_opcode, alu_trig,
      output res_vld, res_data, res_op, res_timeout, fifo_cnt
   );

   modport master (
      output in_vld, in_a, in_b, in_op, alu_data_out, alu_vld, alu_work, res_rdy,
      input  in_rdy, alu_data1, alu_data2, alu_opcode, alu_trig,
      input  res_vld, res_data, res_op, res_timeout, fifo_cnt
   );
endinterface

// File: rtl/fp_alu_dispatch.sv
// Issue stage for the single-precision ALU: request FIFO with subnormal flush, one-shot trig
// protocol towards the ALU, and a single result slot carrying either the ALU answer or a timeout.
module fp_alu_dispatch #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1000
) (
   input logic              sys_clk,
   input logic              sys_rst_n,
   fp_alu_dispatch_if.slave bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
   } req_t;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   function automatic logic [31:0] flush_subnormal(input logic [31:0] x);
      if (x[30:23] == 8'd0 && x[22:0] != 23'd0) begin
         return {x[31], 31'd0};
      end
      return x;
   endfunction

   req_t            mem_q [DEPTH];
   req_t            head;
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] cnt_q;
   logic            can_push;
   logic            push;
   logic            pop;

   state_e          state_q;
   logic [TmoW-1:0] tmo_q;
   logic [31:0]     data1_q;
   logic [31:0]     data2_q;
   logic [1:0]      opcode_q;
   logic            trig_q;
   logic            res_vld_q;
   logic [31:0]     res_data_q;
   logic [1:0]      res_op_q;
   logic            res_timeout_q;

   // Ready looks only at the count, so a full FIFO never accepts in the cycle it pops.
   assign can_push = (cnt_q < CntW'(DEPTH));
   assign push     = bus.in_vld && can_push;
   assign pop      = (state_q == StIdle) && (cnt_q != '0) && !bus.alu_work && !res_vld_q;
   assign head     = mem_q[rd_ptr_q];

   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{a:  flush_subnormal(bus.in_a),
                              b:  flush_subnormal(bus.in_b),
                              op: bus.in_op};
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (pop && !push) begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= StIdle;
         tmo_q         <= '0;
         data1_q       <= '0;
         data2_q       <= '0;
         opcode_q      <= '0;
         trig_q        <= 1'b0;
         res_vld_q     <= 1'b0;
         res_data_q    <= '0;
         res_op_q      <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         if (res_vld_q && bus.res_rdy) begin
            res_vld_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  data1_q  <= head.a;
                  data2_q  <= head.b;
                  opcode_q <= head.op;
                  trig_q   <= 1'b1;
                  state_q  <= StIssue;
               end
            end
            StIssue: begin
               trig_q  <= 1'b0;
               data1_q <= '0;
               data2_q <= '0;
               tmo_q   <= '0;
               state_q <= StWait;
            end
            StWait: begin
               // A result in the same cycle as the last timeout count still counts as a result.
               if (bus.alu_vld) begin
                  res_data_q    <= bus.alu_data_out;
                  res_op_q      <= opcode_q;
                  res_timeout_q <= 1'b0;
                  res_vld_q     <= 1'b1;
                  state_q       <= StIdle;
               end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                  res_data_q    <= 32'hFFFF_FFFF;
                  res_op_q      <= opcode_q;
                  res_timeout_q <= 1'b1;
                  res_vld_q     <= 1'b1;
                  state_q       <= StIdle;
               end else begin
                  tmo_q <= tmo_q + TmoW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_rdy      = can_push;
   assign bus.fifo_cnt    = cnt_q;
   assign bus.alu_data1   = data1_q;
   assign bus.alu_data2   = data2_q;
   assign bus.alu_opcode  = opcode_q;
   assign bus.alu_trig    = trig_q;
   assign bus.res_vld     = res_vld_q;
   assign bus.res_data    = res_data_q;
   assign bus.res_op      = res_op_q;
   assign bus.res_timeout = res_timeout_q;
endmodule

// File: tb/tb_fp_alu_dispatch.sv
// Bench for fp_alu_dispatch: directed vector table, hand-written corner sequences, and a random
// run scored against a queue-based model of the dispatcher with a stand-in ALU.
module tb_fp_alu_dispatch;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 1000;
   localparam int          NCYC    = 3000;
   localparam int          NVEC    = 6;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
   } req_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] ans;
      logic [31:0] exp_d1;
      logic [31:0] exp_d2;
      int          dly;
   } vec_t;

   logic sys_clk;
   logic sys_rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   fp_alu_dispatch_if #(.DEPTH(DEPTH)) bus ();

   fp_alu_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got no end of test, required finish before 5 ms");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Exponent field zero means zero or subnormal; both leave as a signed zero.
   function automatic logic [31:0] ref_flush(input logic [31:0] x);
      return (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
   endfunction

   function automatic logic [31:0] fake_alu(input req_t r);
      return r.a ^ {r.b[15:0], r.b[31:16]} ^ {30'd0, r.op} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 3))
         0:       x[30:23] = 8'h00;
         1:       x[30:23] = 8'hFF;
         2:       x[22:0]  = '0;
         default: ;
      endcase
      return x;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, " in_rdy"}, bus.in_rdy, 1);
      check({tag, " fifo_cnt"}, bus.fifo_cnt, 0);
      check({tag, " trig"}, bus.alu_trig, 0);
      check({tag, " data1"}, bus.alu_data1, 0);
      check({tag, " data2"}, bus.alu_data2, 0);
      check({tag, " opcode"}, bus.alu_opcode, 0);
      check({tag, " res_vld"}, bus.res_vld, 0);
      check({tag, " res_data"}, bus.res_data, 0);
      check({tag, " res_op"}, bus.res_op, 0);
      check({tag, " res_timeout"}, bus.res_timeout, 0);
   endtask

   task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input string tag);
      int n;
      n = 0;
      bus.in_vld = 1'b1;
      bus.in_a   = a;
      bus.in_b   = b;
      bus.in_op  = op;
      while (!bus.in_rdy && n < 50) begin
         tick();
         n++;
      end
      check({tag, " push rdy"}, bus.in_rdy, 1);
      tick();
      bus.in_vld = 1'b0;
   endtask

   // Drive a one-cycle ALU answer now; the result must be visible after the next edge.
   task automatic finish_op(input logic [31:0] ans, input logic [1:0] eop, input string tag);
      bus.alu_vld      = 1'b1;
      bus.alu_data_out = ans;
      tick();
      bus.alu_vld      = 1'b0;
      bus.alu_data_out = 32'h0BAD_F00D;
      check({tag, " res_vld"}, bus.res_vld, 1);
      check({tag, " res_data"}, bus.res_data, ans);
      check({tag, " res_op"}, bus.res_op, eop);
      check({tag, " res_timeout"}, bus.res_timeout, 0);
   endtask

   task automatic serve(input logic [31:0] ea, input logic [31:0] eb, input logic [1:0] eop,
                        input logic [31:0] ans, input int dly, input string tag);
      int n;
      n = 0;
      while (!bus.alu_trig && n < 50) begin
         tick();
         n++;
      end
      check({tag, " trig"}, bus.alu_trig, 1);
      check({tag, " data1"}, bus.alu_data1, ea);
      check({tag, " data2"}, bus.alu_data2, eb);
      check({tag, " opcode"}, bus.alu_opcode, eop);
      tick();
      check({tag, " trig width"}, bus.alu_trig, 0);
      check({tag, " wait data1"}, bus.alu_data1, 0);
      check({tag, " wait data2"}, bus.alu_data2, 0);
      check({tag, " wait opcode"}, bus.alu_opcode, eop);
      repeat (dly - 1) tick();
      finish_op(ans, eop, tag);
   endtask

   vec_t        vt [NVEC];
   req_t        mq [$];
   req_t        cur;
   req_t        preq;
   int          wc, tgt, n_push, n_res, n;
   bit          busy, real_vld, pushed, took, drove, work_prev, trig_prev, exp_vld_before;
   bit          exp_vld, drain;
   logic [31:0] exp_data;
   logic [1:0]  exp_op;

   initial begin
      vt[0] = '{32'h3F80_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3};
      vt[1] = '{32'h8000_0001, 32'h0040_0000, 2'b10, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000, 1};
      vt[2] = '{32'h7F80_0000, 32'h007F_FFFF, 2'b01, 32'hCAFE_0001, 32'h7F80_0000, 32'h0000_0000, 2};
      vt[3] = '{32'h7FC0_0001, 32'h8000_0000, 2'b11, 32'hCAFE_0002, 32'h7FC0_0001, 32'h8000_0000, 5};
      vt[4] = '{32'h0080_0000, 32'h807F_FFFF, 2'b00, 32'hCAFE_0003, 32'h0080_0000, 32'h8000_0000, 1};
      vt[5] = '{32'hFF7F_FFFF, 32'h0000_0001, 2'b10, 32'hCAFE_0004, 32'hFF7F_FFFF, 32'h0000_0000, 4};

      sys_rst_n        = 1'b0;
      bus.in_vld       = 1'b0;
      bus.in_a         = '0;
      bus.in_b         = '0;
      bus.in_op        = '0;
      bus.alu_data_out = '0;
      bus.alu_vld      = 1'b0;
      bus.alu_work     = 1'b0;
      bus.res_rdy      = 1'b1;
      repeat (3) tick();
      check_idle("reset");
      #3 sys_rst_n = 1'b1;
      tick();
      check_idle("post reset");

      // Each vector enters an empty FIFO: count 1 after the push edge, trig after the next.
      for (int i = 0; i < NVEC; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         push_req(vt[i].a, vt[i].b, vt[i].op, tag);
         check({tag, " cnt after push"}, bus.fifo_cnt, 1);
         check({tag, " no early trig"}, bus.alu_trig, 0);
         tick();
         check({tag, " trig latency"}, bus.alu_trig, 1);
         serve(vt[i].exp_d1, vt[i].exp_d2, vt[i].op, vt[i].ans, vt[i].dly, tag);
         tick();
         check({tag, " res cleared"}, bus.res_vld, 0);
      end

      // Full FIFO while the ALU reports busy.
      bus.alu_work = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_vld = 1'b1;
         bus.in_a   = 32'h4000_0000 + 32'(i);
         bus.in_b   = 32'h3F00_0000 + 32'(i);
         bus.in_op  = 2'(i);
         check("fill rdy", bus.in_rdy, 1);
         tick();
      end
      check("full cnt", bus.fifo_cnt, 4);
      check("full rdy", bus.in_rdy, 0);
      bus.in_a  = 32'h4000_0004;
      bus.in_b  = 32'h3F00_0004;
      bus.in_op = 2'd0;
      repeat (3) begin
         tick();
         check("busy no trig", bus.alu_trig, 0);
         check("busy cnt", bus.fifo_cnt, 4);
      end
      bus.alu_work = 1'b0;
      tick();
      check("release trig", bus.alu_trig, 1);
      check("release cnt", bus.fifo_cnt, 3);
      check("release rdy", bus.in_rdy, 1);
      check("release data1", bus.alu_data1, 32'h4000_0000);
      tick();
      bus.in_vld = 1'b0;
      check("fifth accepted", bus.fifo_cnt, 4);
      finish_op(32'hAAAA_0000, 2'd0, "full0");
      for (int i = 1; i < 5; i++) begin
         serve(32'h4000_0000 + 32'(i), 32'h3F00_0000 + 32'(i), 2'(i), 32'hAAAA_0000 + 32'(i), 1,
               $sformatf("full%0d", i));
      end
      tick();

      // Result slot held: no new issue until it is consumed.
      bus.res_rdy = 1'b0;
      push_req(32'h4100_0000, 32'h4110_0000, 2'b01, "hold0");
      push_req(32'h4120_0000, 32'h4130_0000, 2'b11, "hold1");
      serve(32'h4100_0000, 32'h4110_0000, 2'b01, 32'h1111_1111, 2, "hold0");
      repeat (4) begin
         tick();
         check("hold res_vld", bus.res_vld, 1);
         check("hold res_data", bus.res_data, 32'h1111_1111);
         check("hold no trig", bus.alu_trig, 0);
         check("hold cnt", bus.fifo_cnt, 1);
      end
      bus.res_rdy = 1'b1;
      tick();
      bus.res_rdy = 1'b0;
      check("hold consumed", bus.res_vld, 0);
      check("hold trig wait", bus.alu_trig, 0);
      tick();
      check("hold next trig", bus.alu_trig, 1);
      serve(32'h4120_0000, 32'h4130_0000, 2'b11, 32'h2222_2222, 1, "hold1");
      bus.res_rdy = 1'b1;
      tick();
      tick();

      // No ALU answer: one issue cycle then TIMEOUT wait cycles before the marker.
      push_req(32'h4200_0000, 32'h4210_0000, 2'b10, "tmo0");
      push_req(32'h4220_0000, 32'h4230_0000, 2'b01, "tmo1");
      n = 0;
      while (!bus.alu_trig && n < 20) begin
         tick();
         n++;
      end
      check("tmo trig", bus.alu_trig, 1);
      n = 0;
      while (!bus.res_vld && n < int'(TIMEOUT) + 100) begin
         tick();
         n++;
      end
      check("tmo latency", 32'(n), 32'(TIMEOUT + 1));
      check("tmo res_data", bus.res_data, 32'hFFFF_FFFF);
      check("tmo flag", bus.res_timeout, 1);
      check("tmo res_op", bus.res_op, 2'b10);
      tick();
      serve(32'h4220_0000, 32'h4230_0000, 2'b01, 32'h3333_3333, 2, "tmo next");
      tick();

      // Reset in the middle of a wait drops the operation; a late ALU answer is ignored.
      push_req(32'h4300_0000, 32'h4310_0000, 2'b11, "rst");
      n = 0;
      while (!bus.alu_trig && n < 20) begin
         tick();
         n++;
      end
      check("rst trig", bus.alu_trig, 1);
      repeat (3) tick();
      #2 sys_rst_n = 1'b0;
      #1;
      check_idle("rst async");
      #2 sys_rst_n = 1'b1;
      tick();
      bus.alu_vld      = 1'b1;
      bus.alu_data_out = 32'hDEAD_BEEF;
      tick();
      bus.alu_vld = 1'b0;
      tick();
      tick();
      check_idle("rst after");

      // Random traffic against the queue model.
      busy = 0; exp_vld = 0; pushed = 0; took = 0; drove = 0; work_prev = 0; trig_prev = 0;
      n_push = 0; n_res = 0; exp_data = '0; exp_op = '0; wc = 0; tgt = 1;
      for (int cyc = 0; cyc < NCYC + 2000; cyc++) begin
         drain          = (cyc >= NCYC);
         exp_vld_before = exp_vld;
         if (pushed) begin
            mq.push_back('{a: ref_flush(preq.a), b: ref_flush(preq.b), op: preq.op});
            n_push++;
         end
         if (took) begin
            exp_vld = 0;
            n_res++;
         end
         if (drove) begin
            exp_vld  = 1;
            exp_data = fake_alu(cur);
            exp_op   = cur.op;
         end
         if (drain && mq.size() == 0 && !busy && !exp_vld) break;

         if (bus.alu_trig) begin
            check("rnd trig single", trig_prev, 0);
            check("rnd trig gate", {30'd0, exp_vld_before, work_prev}, 0);
            if (mq.size() == 0) begin
               check("rnd trig with empty queue", bus.alu_trig, 0);
            end else begin
               cur = mq.pop_front();
               check("rnd data1", bus.alu_data1, cur.a);
               check("rnd data2", bus.alu_data2, cur.b);
               check("rnd opcode", bus.alu_opcode, cur.op);
            end
            busy = 1;
            wc   = 0;
            tgt  = $urandom_range(1, 6);
         end

         check("rnd fifo_cnt", bus.fifo_cnt, 32'(mq.size()));
         check("rnd in_rdy", bus.in_rdy, (mq.size() < DEPTH) ? 1 : 0);
         check("rnd res_vld", bus.res_vld, exp_vld);
         if (exp_vld) begin
            check("rnd res_data", bus.res_data, exp_data);
            check("rnd res_op", bus.res_op, exp_op);
            check("rnd res_timeout", bus.res_timeout, 0);
         end

         real_vld         = 0;
         bus.alu_vld      = 1'b0;
         bus.alu_data_out = $urandom;
         if (busy && !bus.alu_trig) wc++;
         if (busy && wc == tgt) begin
            bus.alu_vld      = 1'b1;
            bus.alu_data_out = fake_alu(cur);
            real_vld         = 1;
            busy             = 0;
         end else if (!busy && $urandom_range(0, 9) == 0) begin
            bus.alu_vld = 1'b1;
         end
         bus.in_vld   = (!drain && $urandom_range(0, 9) < 6);
         bus.in_a     = rnd_fp();
         bus.in_b     = rnd_fp();
         bus.in_op    = 2'($urandom_range(0, 3));
         bus.res_rdy  = 1'($urandom_range(0, 1));
         bus.alu_work = ($urandom_range(0, 4) == 0);

         pushed    = bus.in_vld && (mq.size() < DEPTH);
         preq      = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
         took      = exp_vld && bus.res_rdy;
         drove     = real_vld;
         work_prev = bus.alu_work;
         trig_prev = bus.alu_trig;
         tick();
      end
      check("rnd drained queue", 32'(mq.size()), 0);
      check("rnd drained busy", {31'd0, busy}, 0);
      check("rnd results", 32'(n_res), 32'(n_push));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
